// File: rtl/matrix_pkg.sv
// Shared types and constants for the row-sequential matrix multiplier:
// FSM encoding, datapath opcodes and bus widths.
package matrix_pkg;

    localparam int DATA_W    = 256;
    localparam int CNT_W     = 32;
    localparam int WORD_W    = 32;
    localparam int NUM_LANES = DATA_W / WORD_W;
    localparam int ADDR_W    = 3;
    localparam int OP_W      = 6;
    localparam int K_LAST    = NUM_LANES - 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_MAC   = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // mm_op 1..8 selects A-row word 0..7; 0 means no operation
    localparam logic [OP_W-1:0] OP_NOP   = 6'd0;
    localparam logic [OP_W-1:0] OP_FIRST = 6'd1;
    localparam logic [OP_W-1:0] OP_LAST  = 6'd8;

    typedef struct packed {
        logic              en;
        logic [OP_W-1:0]   op;
    } mm_ctrl_t;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } c_req_t;

    function automatic logic [OP_W-1:0] op_for_k(input logic [ADDR_W-1:0] k);
        return OP_FIRST + OP_W'(k);
    endfunction

endpackage

// File: rtl/matrix_ops.sv
// Vector MAC datapath: co = cin + a[word mm_op-1] * b, lane-wise over
// NUM_LANES 32-bit words, products and sums truncated to 32 bits.
module matrix_ops
    import matrix_pkg::*;
(
    input  logic              mm_en,
    input  logic [OP_W-1:0]   mm_op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] cin,
    output logic [DATA_W-1:0] co
);

    logic [NUM_LANES-1:0][WORD_W-1:0] a_l, b_l, cin_l, co_l;
    logic [ADDR_W-1:0]                widx;
    logic [WORD_W-1:0]                a_word;
    logic                             op_ok;

    assign a_l    = a;
    assign b_l    = b;
    assign cin_l  = cin;
    assign op_ok  = mm_en && (mm_op >= OP_FIRST) && (mm_op <= OP_LAST);
    assign widx   = ADDR_W'(mm_op - OP_FIRST);
    assign a_word = a_l[widx];

    // the selected A word is broadcast to every lane
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        matrix_ops_lane u_lane (
            .en    (op_ok),
            .a_word(a_word),
            .b     (b_l[l]),
            .cin   (cin_l[l]),
            .co    (co_l[l])
        );
    end

    assign co = co_l;

endmodule

module matrix_ops_lane
    import matrix_pkg::*;
(
    input  logic              en,
    input  logic [WORD_W-1:0] a_word,
    input  logic [WORD_W-1:0] b,
    input  logic [WORD_W-1:0] cin,
    output logic [WORD_W-1:0] co
);

    logic [WORD_W-1:0] prod;

    assign prod = a_word * b;
    assign co   = en ? (cin + prod) : cin;

endmodule

// File: rtl/matrix_mul_seq.sv
// Row-sequential C = A x B controller: per row FETCH, 8 MAC beats, WRITE.
// Optional busy-cycle counter enabled by defining MATRIX_SEQ_PERF_EN.
module matrix_mul_seq
    import matrix_pkg::*;
#(
    parameter int ROWS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              a_rd,
    output logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              b_rd,
    output logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              c_wr,
    output logic [ADDR_W-1:0] c_addr,
    output logic [DATA_W-1:0] c_data,
    input  logic              c_ready,
    output logic              mm_en,
    output logic [OP_W-1:0]   mm_op,
    output logic [DATA_W-1:0] acc_out,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] K_MAX    = ADDR_W'(K_LAST);

    state_t            state, nstate;
    logic [ADDR_W-1:0] row, k;
    logic [DATA_W-1:0] acc, a_reg, dp_a, dp_co;
    mm_ctrl_t          ctrl;
    c_req_t            creq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            ST_IDLE:  if (start) nstate = ST_FETCH;
            ST_FETCH: nstate = ST_MAC;
            ST_MAC:   if (k == K_MAX) nstate = ST_WRITE;
            ST_WRITE: if (c_ready) nstate = (row == ROW_LAST) ? ST_DONE : ST_FETCH;
            ST_DONE:  nstate = ST_IDLE;
            default:  nstate = ST_IDLE;
        endcase
    end

    always_comb begin
        a_rd   = 1'b0;
        a_addr = '0;
        b_rd   = 1'b0;
        b_addr = '0;
        creq   = '0;
        ctrl   = '0;
        done   = 1'b0;
        case (state)
            ST_FETCH: begin
                a_rd   = 1'b1;
                a_addr = row;
                b_rd   = 1'b1;
            end
            ST_MAC: begin
                ctrl.en = 1'b1;
                ctrl.op = op_for_k(k);
                if (k != K_MAX) begin
                    b_rd   = 1'b1;
                    b_addr = k + 1'b1;
                end
            end
            ST_WRITE: begin
                creq.wr   = 1'b1;
                creq.addr = row;
                creq.data = acc;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign busy    = (state != ST_IDLE);
    assign mm_en   = ctrl.en;
    assign mm_op   = ctrl.op;
    assign c_wr    = creq.wr;
    assign c_addr  = creq.addr;
    assign c_data  = creq.data;
    assign acc_out = acc;

    // A row arrives on the first MAC beat; later beats reuse the latched copy
    assign dp_a = (k == '0) ? a_data : a_reg;

    matrix_ops u_ops (
        .mm_en(ctrl.en),
        .mm_op(ctrl.op),
        .a    (dp_a),
        .b    (b_data),
        .cin  (acc),
        .co   (dp_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row   <= '0;
            k     <= '0;
            acc   <= '0;
            a_reg <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    acc <= '0;
                    k   <= '0;
                end
                ST_MAC: begin
                    acc <= dp_co;
                    if (k == '0) a_reg <= a_data;
                    if (k != K_MAX) k <= k + 1'b1;
                end
                ST_WRITE: if (c_ready && row != ROW_LAST) row <= row + 1'b1;
                ST_DONE:  row <= '0;
                default: ;
            endcase
        end
    end

`ifdef MATRIX_SEQ_PERF_EN
    logic [CNT_W-1:0] cyc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         cyc_q <= '0;
        else if (state == ST_IDLE && start) cyc_q <= '0;
        else if (busy)                      cyc_q <= cyc_q + 1'b1;
    end

    assign cycle_count = cyc_q;
`else
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_matrix_mul_seq.sv
// Directed bench for matrix_mul_seq: ROWS=8 instance for the main jobs,
// ROWS=1 instance for the single-row case.
module tb_matrix_mul_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0, start1 = 1'b0;
    logic         busy, done, a_rd, b_rd, c_wr, mm_en;
    logic [2:0]   a_addr, b_addr, c_addr;
    logic [255:0] a_data, b_data, c_data, acc_out;
    logic         c_ready = 1'b1;
    logic [5:0]   mm_op;
    logic [31:0]  cycle_count;

    logic         busy1, done1, a_rd1, b_rd1, c_wr1, mm_en1;
    logic [2:0]   a_addr1, b_addr1, c_addr1;
    logic [255:0] a_data1, b_data1, c_data1, acc_out1;
    logic         c_ready1 = 1'b1;
    logic [5:0]   mm_op1;
    logic [31:0]  cycle_count1;

    logic [255:0] amem [8];
    logic [255:0] bmem [8];

    int errors = 0, checks = 0;
    int wr_cnt = 0, done_cnt = 0, b_rd_cnt = 0, wr1_cnt = 0;
    logic [2:0]   c_log_addr [64];
    logic [255:0] c_log_data [64];
    logic [2:0]   c1_addr_log;
    logic [255:0] c1_data_log;

    always #5 clk = ~clk;

    matrix_mul_seq #(.ROWS(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .a_rd(a_rd), .a_addr(a_addr), .a_data(a_data),
        .b_rd(b_rd), .b_addr(b_addr), .b_data(b_data),
        .c_wr(c_wr), .c_addr(c_addr), .c_data(c_data), .c_ready(c_ready),
        .mm_en(mm_en), .mm_op(mm_op), .acc_out(acc_out), .cycle_count(cycle_count)
    );

    matrix_mul_seq #(.ROWS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
        .a_rd(a_rd1), .a_addr(a_addr1), .a_data(a_data1),
        .b_rd(b_rd1), .b_addr(b_addr1), .b_data(b_data1),
        .c_wr(c_wr1), .c_addr(c_addr1), .c_data(c_data1), .c_ready(c_ready1),
        .mm_en(mm_en1), .mm_op(mm_op1), .acc_out(acc_out1), .cycle_count(cycle_count1)
    );

    // memories with one-cycle read latency, plus write/done/read logging
    always @(posedge clk) begin
        if (a_rd)  a_data  <= amem[a_addr];
        if (b_rd)  b_data  <= bmem[b_addr];
        if (a_rd1) a_data1 <= amem[a_addr1];
        if (b_rd1) b_data1 <= bmem[b_addr1];
        if (b_rd)  b_rd_cnt <= b_rd_cnt + 1;
        if (done)  done_cnt <= done_cnt + 1;
        if (c_wr && c_ready) begin
            c_log_addr[wr_cnt] <= c_addr;
            c_log_data[wr_cnt] <= c_data;
            wr_cnt <= wr_cnt + 1;
        end
        if (c_wr1 && c_ready1) begin
            c1_addr_log <= c_addr1;
            c1_data_log <= c_data1;
            wr1_cnt <= wr1_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start, then wait for done; optional stall on one row's write and
    // optional spurious start during MAC of one row. cyc = cycle index of done.
    task automatic run_job(input int stall_row, input int inject_row, output int cyc);
        int  base, b0;
        bit  stalled, injected;
        logic [255:0] held;
        base = wr_cnt; stalled = 0; injected = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 300) begin
            if (stall_row >= 0 && !stalled && c_wr && c_addr == 3'(stall_row)) begin
                stalled = 1;
                c_ready = 1'b0;
                held = c_data;
                b0 = b_rd_cnt;
                repeat (5) begin
                    @(posedge clk); #1; cyc++;
                    check("stall_c_wr", 256'(c_wr), 256'd1);
                    check("stall_c_data", c_data, held);
                end
                check("stall_b_reads", 256'(b_rd_cnt - b0), 256'd0);
                c_ready = 1'b1;
            end
            if (inject_row >= 0 && !injected && (wr_cnt - base) == inject_row && mm_en) begin
                injected = 1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1; cyc++;
        end
        start = 1'b0;
        if (cyc >= 300) check("done_timeout", 256'(cyc), 256'd0);
    endtask

    initial begin
        int cyc, base, dbase, bbase;

        for (int i = 0; i < 8; i++) begin
            amem[i] = '0;
            amem[i][32*i +: 32] = 32'd1;
            bmem[i] = {8{32'(i + 1)}};
        end

        // reset state
        #12;
        check("rst_busy", 256'(busy), 256'd0);
        check("rst_done", 256'(done), 256'd0);
        check("rst_strobes", 256'({a_rd, b_rd, c_wr, mm_en}), 256'd0);
        check("rst_mm_op", 256'(mm_op), 256'd0);
        check("rst_addrs", 256'({a_addr, b_addr, c_addr}), 256'd0);
        check("rst_acc", acc_out, 256'd0);
        check("rst_cycle_count", 256'(cycle_count), 256'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // job 1: identity A, first cycles stepped by hand
        base = wr_cnt; dbase = done_cnt; bbase = b_rd_cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("fetch_strobes", 256'({busy, a_rd, b_rd, mm_en}), 256'b1110);
        check("fetch_addrs", 256'({a_addr, b_addr}), 256'd0);
        @(posedge clk); #1;
        check("mac0_ctrl", 256'({mm_en, mm_op}), 256'({1'b1, 6'd1}));
        check("mac0_b_read", 256'({b_rd, b_addr}), 256'({1'b1, 3'd1}));
        repeat (7) @(posedge clk);
        #1;
        check("mac7_ctrl", 256'({mm_en, mm_op, b_rd}), 256'({1'b1, 6'd8, 1'b0}));
        cyc = 9;
        while (!done && cyc < 300) begin
            @(posedge clk); #1; cyc++;
        end
        check("job1_done_cycle", 256'(cyc), 256'd81);
        check("job1_busy_in_done", 256'(busy), 256'd1);
        @(posedge clk); #1;
        check("job1_idle_after", 256'({busy, done}), 256'd0);
        check("job1_writes", 256'(wr_cnt - base), 256'd8);
        check("job1_b_reads", 256'(b_rd_cnt - bbase), 256'd64);
        check("job1_done_pulses", 256'(done_cnt - dbase), 256'd1);
        for (int i = 0; i < 8; i++) begin
            check("job1_c_addr", 256'(c_log_addr[base + i]), 256'(i));
            check("job1_c_data", c_log_data[base + i], {8{32'(i + 1)}});
        end
`ifdef MATRIX_SEQ_PERF_EN
        check("job1_cycle_count", 256'(cycle_count), 256'd81);
`else
        check("job1_cycle_count", 256'(cycle_count), 256'd0);
`endif

        // job 2: back-pressure on row 3
        base = wr_cnt; bbase = b_rd_cnt;
        run_job(3, -1, cyc);
        check("stall_done_cycle", 256'(cyc), 256'd86);
        check("stall_writes", 256'(wr_cnt - base), 256'd8);
        check("stall_b_reads_total", 256'(b_rd_cnt - bbase), 256'd64);
        check("stall_row3_data", c_log_data[base + 3], {8{32'd4}});
        @(posedge clk); #1;

        // job 3: start pulsed during MAC of row 2
        base = wr_cnt; dbase = done_cnt;
        run_job(-1, 2, cyc);
        check("inject_done_cycle", 256'(cyc), 256'd81);
        repeat (15) @(posedge clk);
        #1;
        check("inject_writes", 256'(wr_cnt - base), 256'd8);
        check("inject_done_pulses", 256'(done_cnt - dbase), 256'd1);
        check("inject_idle", 256'(busy), 256'd0);

        // job 4: all-ones A rows, reset during MAC k=4 of row 5
        for (int i = 0; i < 8; i++) amem[i] = {8{32'd1}};
        base = wr_cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (!((wr_cnt - base) == 5 && mm_en && mm_op == 6'd5) && cyc < 300) begin
            @(posedge clk); #1; cyc++;
        end
        check("rst_point_cycle", 256'(cyc), 256'd56);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 256'({busy, done}), 256'd0);
        check("midrst_strobes", 256'({a_rd, b_rd, c_wr, mm_en}), 256'd0);
        check("midrst_mm_op", 256'(mm_op), 256'd0);
        check("midrst_addrs", 256'({a_addr, b_addr, c_addr}), 256'd0);
        check("midrst_acc", acc_out, 256'd0);
        check("midrst_cycle_count", 256'(cycle_count), 256'd0);
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_write", 256'(wr_cnt - base), 256'd5);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        base = wr_cnt;
        run_job(-1, -1, cyc);
        check("rerun_done_cycle", 256'(cyc), 256'd81);
        check("rerun_writes", 256'(wr_cnt - base), 256'd8);
        for (int i = 0; i < 8; i++) begin
            check("rerun_c_addr", 256'(c_log_addr[base + i]), 256'(i));
            check("rerun_c_data", c_log_data[base + i], {8{32'd36}});
        end
`ifdef MATRIX_SEQ_PERF_EN
        check("rerun_cycle_count", 256'(cycle_count), 256'd81);
`else
        check("rerun_cycle_count", 256'(cycle_count), 256'd0);
`endif
        @(posedge clk); #1;

        // ROWS=1 instance
        for (int i = 0; i < 8; i++) begin
            amem[i] = '0;
            bmem[i] = '0;
        end
        amem[0] = 256'd3;
        bmem[0] = {8{32'd2}};
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        cyc = 1;
        while (!done1 && cyc < 300) begin
            @(posedge clk); #1; cyc++;
        end
        check("rows1_done_cycle", 256'(cyc), 256'd11);
        check("rows1_writes", 256'(wr1_cnt), 256'd1);
        check("rows1_c_addr", 256'(c1_addr_log), 256'd0);
        check("rows1_c_data", c1_data_log, {8{32'd6}});
        check("rows1_busy_in_done", 256'(busy1), 256'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/matrix_mul_seq.md
MATRIX_MUL_SEQ -- requirements
Module: matrix_mul_seq

Interface
REQ-001 SHALL have parameter ROWS, default 8, number of C rows computed per job (legal 1..8).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 SHALL have port start  input  1  job request, sampled in IDLE only.
REQ-005 SHALL have port busy  output  1  high from the cycle after accepted start until DONE exits.
REQ-006 SHALL have port done  output  1  single-cycle pulse on job completion.
REQ-007 SHALL have ports a_rd/a_addr  output  1/3  A-row read strobe and row index; a_data  input  256  valid one cycle after a_rd.
REQ-008 SHALL have ports b_rd/b_addr  output  1/3  B-row read strobe and row index; b_data  input  256  valid one cycle after b_rd.
REQ-009 SHALL have ports c_wr/c_addr/c_data  output  1/3/256  C-row write; c_ready  input  1  write accepted when c_wr and c_ready are both high.
REQ-010 SHALL have ports mm_en/mm_op  output  1/6  datapath control; acc_out  output  256  accumulator presented to datapath cin.
REQ-011 SHALL have port cycle_count  output  32  busy-cycle count (see Configuration).

Function
REQ-012 SHALL implement states IDLE, FETCH, MAC, WRITE, DONE.
REQ-013 IDLE->FETCH when start=1; start while not in IDLE SHALL be ignored.
REQ-014 FETCH (1 cycle): a_rd=1, a_addr=row; b_rd=1, b_addr=0; acc cleared to 0; k=0.
REQ-015 FETCH->MAC unconditionally; on first MAC cycle a_data SHALL be latched into an A-row register.
REQ-016 MAC lasts exactly 8 cycles, k=0..7: mm_en=1, mm_op=k+1, datapath a=A-row register (a_data on k=0), b=b_data, cin=acc; acc<=co.
REQ-017 In MAC for k<7: b_rd=1, b_addr=k+1; k=7 issues no read.
REQ-018 mm_en SHALL be 0 and mm_op 0 outside MAC.
REQ-019 MAC(k=7)->WRITE; WRITE holds c_wr=1, c_addr=row, c_data=acc until c_ready=1.
REQ-020 On accepted write: if row=ROWS-1 -> DONE, else row+1 and ->FETCH.
REQ-021 DONE (1 cycle): done=1, busy=0 in the following cycle; DONE->IDLE; row reset to 0.
REQ-022 Latency with c_ready tied high: SHALL be 10 cycles per row, done asserted 10*ROWS+1 cycles after the start-sampling edge.
REQ-023 acc SHALL capture co unmodified; width and truncation are owned by the datapath.
REQ-024 Row and k counters SHALL not wrap past ROWS-1 and 7 respectively.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, row=0, k=0, acc=0, A-row register=0, all strobes/done/busy/mm_en=0, mm_op=0, c_addr/a_addr/b_addr=0, cycle_count=0.
REQ-026 Reset mid-job SHALL abandon the job with no further C write; outputs return to IDLE values before next clk edge.

Configuration
REQ-027 With MATRIX_SEQ_PERF_EN defined, cycle_count SHALL clear on accepted start, increment every cycle busy=1, hold after DONE.
REQ-028 Without MATRIX_SEQ_PERF_EN, cycle_count SHALL be constant 0 and no counter logic SHALL be generated.

Structure
REQ-029 State encoding, mm_op values 1..8, and the 256/32 widths SHALL live in a shared package matrix_pkg.
REQ-030 One sub-module SHALL be instantiated: matrix_ops, driven by mm_en/mm_op/a/b/cin; the FSM stays in matrix_mul_seq.

Verification
REQ-031 A=identity (word i of row i =1), B rows k = {8{k+1}} small values, c_ready=1 -> C row i equals B row i; done at cycle 81 for ROWS=8.
REQ-032 c_ready held 0 for 5 cycles on row 3 -> c_wr/c_data stable throughout, no extra B reads, completion delayed exactly 5 cycles.
REQ-033 start pulsed during MAC of row 2 -> ignored, exactly ROWS writes, one done pulse.
REQ-034 rst_n low during MAC k=4 of row 5 -> all outputs at reset values asynchronously; new start runs full job from row 0.
REQ-035 ROWS=1, A row0 word0=3, B row0={8{2}}, others 0 -> single write c_addr=0, c_data={8{6}}, done at cycle 11.
REQ-036 MATRIX_SEQ_PERF_EN defined, ROWS=8, c_ready=1 -> cycle_count=81 after done; undefined -> 0.
